// File: rtl/pixmem_if.sv
// -----------------------------------------------------------------------------
// pixmem_if
//
// Multi-bank pixel memory sitting between the display-side design (which reads
// single pixels) and a host-side loader (which writes whole words or asks the
// hardware to fill a complete bank with one value).
//
// Ports
//   clk_i         single clock for all logic and memory
//   rst_ni        synchronous, active-low reset
//   addr_i        display read word address
//   bank_i        display read bank
//   pix_sel_i     pixel index inside the addressed word
//   pixel_o       selected pixel, 2 cycles after addr_i/bank_i/pix_sel_i
//   wr_valid_i    host write request
//   wr_ready_o    host write accepted this cycle when high with wr_valid_i
//   wr_bank_i     host write bank
//   wr_addr_i     host write word address
//   wr_data_i     host write word
//   fill_start_i  single-cycle request to fill a whole bank
//   fill_bank_i   fill target bank (sampled with fill_start_i)
//   fill_value_i  fill word (sampled with fill_start_i)
//   fill_busy_o   fill engine active
//   fill_done_o   one-cycle pulse after the last fill write
//   dbg_state_o   current fill FSM state (0 = IDLE, 1 = FILL)
//
// Host write handshake: a transfer happens on every rising edge where
// wr_valid_i and wr_ready_o are both high. wr_ready_o is combinational and
// may drop and rise while wr_valid_i is held; the host keeps the payload
// stable until the transfer edge, so a stalled request never loses data.
// -----------------------------------------------------------------------------
module pixmem_if #(
    parameter int PIX_W        = 4,
    parameter int PIX_PER_WORD = 8,
    parameter int ADDR_W       = 9,
    parameter int NUM_BANKS    = 2,
    localparam int SEL_W       = $clog2(PIX_PER_WORD),
    localparam int BANK_W      = $clog2(NUM_BANKS),
    localparam int WORD_W      = PIX_W * PIX_PER_WORD
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [BANK_W-1:0] bank_i,
    input  logic [SEL_W-1:0]  pix_sel_i,
    output logic [PIX_W-1:0]  pixel_o,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    input  logic [BANK_W-1:0] wr_bank_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WORD_W-1:0] wr_data_i,
    input  logic              fill_start_i,
    input  logic [BANK_W-1:0] fill_bank_i,
    input  logic [WORD_W-1:0] fill_value_i,
    output logic              fill_busy_o,
    output logic              fill_done_o,
    output logic              dbg_state_o
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] CNT_LAST = '1;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_e;

    // ------------------------------------------------------------------
    // Storage: one synchronous port per bank. The display read always owns
    // the port of the bank it points at, so writes are only ever issued to
    // a different bank and at most one write happens per cycle overall.
    // ------------------------------------------------------------------
    logic [WORD_W-1:0] mem_q [NUM_BANKS][DEPTH];

    // Fill FSM registers
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [BANK_W-1:0] fbank_q, fbank_d;
    logic [WORD_W-1:0] fval_q, fval_d;
    logic              done_q, done_d;

    // Read pipeline registers
    logic [WORD_W-1:0] word_q;
    logic [SEL_W-1:0]  sel_q;
    logic [PIX_W-1:0]  pixel_q;

    // Write port control
    logic              fill_stall;
    logic              fill_we;
    logic              host_we;
    logic              mem_we;
    logic [BANK_W-1:0] mem_wbank;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WORD_W-1:0] mem_wdata;

    // Pixel lanes of the registered word
    logic [PIX_W-1:0]  pix_lane [PIX_PER_WORD];

    // ------------------------------------------------------------------
    // Write arbitration
    // ------------------------------------------------------------------
    // Host writes are only possible while no fill is running and the host
    // targets a bank other than the one being displayed.
    assign wr_ready_o = rst_ni && (state_q == IDLE) && (wr_bank_i != bank_i);
    assign host_we    = wr_valid_i && wr_ready_o;

    // The fill engine yields to the display read when they share a bank.
    // Gating with rst_ni keeps a fill interrupted by reset from writing the
    // word it was about to write.
    assign fill_stall = (fbank_q == bank_i);
    assign fill_we    = rst_ni && (state_q == FILL) && !fill_stall;

    // Host and fill writes are mutually exclusive (host needs IDLE, fill
    // needs FILL), so a simple priority mux is enough.
    always_comb begin
        mem_we    = 1'b0;
        mem_wbank = wr_bank_i;
        mem_waddr = wr_addr_i;
        mem_wdata = wr_data_i;
        if (fill_we) begin
            mem_we    = 1'b1;
            mem_wbank = fbank_q;
            mem_waddr = cnt_q;
            mem_wdata = fval_q;
        end else if (host_we) begin
            mem_we = 1'b1;
        end
    end

    // Memory contents are intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[mem_wbank][mem_waddr] <= mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Fill FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fbank_d = fbank_q;
        fval_d  = fval_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (fill_start_i) begin
                    state_d = FILL;
                    cnt_d   = '0;
                    fbank_d = fill_bank_i;
                    fval_d  = fill_value_i;
                end
            end
            FILL: begin
                // fill_start_i is ignored here: a running fill is never
                // restarted. A stall simply holds cnt for that cycle.
                if (!fill_stall) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Fill FSM: state register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fbank_q <= '0;
            fval_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fbank_q <= fbank_d;
            fval_q  <= fval_d;
            done_q  <= done_d;
        end
    end

    assign fill_busy_o = (state_q == FILL);
    assign fill_done_o = done_q;
    assign dbg_state_o = state_q;

    // ------------------------------------------------------------------
    // Read pipeline: stage 1 reads the word and delays pix_sel alongside
    // it, stage 2 picks the pixel. Latency is fixed at two cycles whether
    // the address, the bank or only pix_sel changes.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < PIX_PER_WORD; i++) begin : g_lane
        assign pix_lane[i] = word_q[i*PIX_W +: PIX_W];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            word_q  <= '0;
            sel_q   <= '0;
            pixel_q <= '0;
        end else begin
            word_q  <= mem_q[bank_i][addr_i];
            sel_q   <= pix_sel_i;
            pixel_q <= pix_lane[sel_q];
        end
    end

    assign pixel_o = pixel_q;

endmodule

// File: tb/tb_pixmem_if.sv
// -----------------------------------------------------------------------------
// tb_pixmem_if
//
// Directed bench for pixmem_if: reset state, host writes and pixel selection
// (table of read vectors applied back to back), write/read ordering, write
// stall on bank conflict, bank fills with and without display stalls, a fill
// cut short by reset, and a fill started together with a host write.
// -----------------------------------------------------------------------------
module tb_pixmem_if;

    localparam int PIX_W        = 4;
    localparam int PIX_PER_WORD = 8;
    localparam int ADDR_W       = 9;
    localparam int NUM_BANKS    = 2;
    localparam int SEL_W        = $clog2(PIX_PER_WORD);
    localparam int BANK_W       = $clog2(NUM_BANKS);
    localparam int WORD_W       = PIX_W * PIX_PER_WORD;
    localparam int NVEC         = 15;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] addr;
    logic [BANK_W-1:0] bank;
    logic [SEL_W-1:0]  pix_sel;
    logic [PIX_W-1:0]  pixel;
    logic              wr_valid;
    logic              wr_ready;
    logic [BANK_W-1:0] wr_bank;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;
    logic              fill_start;
    logic [BANK_W-1:0] fill_bank;
    logic [WORD_W-1:0] fill_value;
    logic              fill_busy;
    logic              fill_done;
    logic              dbg_state;

    int total;
    int bad;

    typedef struct {
        logic [BANK_W-1:0] bank;
        logic [ADDR_W-1:0] addr;
        logic [SEL_W-1:0]  sel;
        logic [PIX_W-1:0]  exp;
    } rd_vec_t;

    rd_vec_t vecs [NVEC];

    pixmem_if #(
        .PIX_W       (PIX_W),
        .PIX_PER_WORD(PIX_PER_WORD),
        .ADDR_W      (ADDR_W),
        .NUM_BANKS   (NUM_BANKS)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .addr_i      (addr),
        .bank_i      (bank),
        .pix_sel_i   (pix_sel),
        .pixel_o     (pixel),
        .wr_valid_i  (wr_valid),
        .wr_ready_o  (wr_ready),
        .wr_bank_i   (wr_bank),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .fill_start_i(fill_start),
        .fill_bank_i (fill_bank),
        .fill_value_i(fill_value),
        .fill_busy_o (fill_busy),
        .fill_done_o (fill_done),
        .dbg_state_o (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled 1 ns after
    // the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Single accepted host write (the caller guarantees wr_bank != bank).
    task automatic host_write(input logic [BANK_W-1:0] b, input logic [ADDR_W-1:0] a,
                              input logic [WORD_W-1:0] d);
        wr_bank  = b;
        wr_addr  = a;
        wr_data  = d;
        wr_valid = 1'b1;
        #1;
        check("wr_ready_idle", {63'd0, wr_ready}, 64'd1);
        tick();
        wr_valid = 1'b0;
    endtask

    // Isolated read: present address, wait out the 2-cycle latency.
    task automatic read_pix(input logic [BANK_W-1:0] b, input logic [ADDR_W-1:0] a,
                            input logic [SEL_W-1:0] s, output logic [PIX_W-1:0] p);
        bank    = b;
        addr    = a;
        pix_sel = s;
        tick();
        tick();
        p = pixel;
    endtask

    // Start a fill and run it to completion (bounded). Optionally moves the
    // display onto the fill bank for stall_len cycles starting at stall_at,
    // and pulses fill_start again mid-fill to show it is ignored.
    task automatic run_fill(input logic [BANK_W-1:0] fb, input logic [WORD_W-1:0] fv,
                            input int stall_at, input int stall_len,
                            output int busy_n, output bit ready_hi);
        logic [BANK_W-1:0] orig_bank;
        orig_bank  = bank;
        fill_bank  = fb;
        fill_value = fv;
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        wr_valid   = 1'b0;
        wr_bank    = ~orig_bank;
        busy_n     = 0;
        ready_hi   = 1'b0;
        while (fill_busy && busy_n < 2000) begin
            if (wr_ready) ready_hi = 1'b1;
            if (busy_n == 200) begin
                fill_start = 1'b1;
                fill_bank  = orig_bank;
                fill_value = '0;
            end else begin
                fill_start = 1'b0;
            end
            if (busy_n == stall_at) bank = fb;
            if (busy_n == stall_at + stall_len) bank = orig_bank;
            busy_n++;
            tick();
        end
        fill_start = 1'b0;
        bank       = orig_bank;
    endtask

    initial begin
        logic [PIX_W-1:0] p;
        int               busy_n;
        bit               ready_hi;
        int               word_bad;

        total = 0;
        bad   = 0;

        // Read vectors: {bank, addr, sel, expected pixel}
        vecs[0]  = '{1'b1, 9'h055, 3'd0, 4'h0};
        vecs[1]  = '{1'b1, 9'h055, 3'd1, 4'h1};
        vecs[2]  = '{1'b1, 9'h055, 3'd2, 4'h2};
        vecs[3]  = '{1'b1, 9'h055, 3'd3, 4'h3};
        vecs[4]  = '{1'b1, 9'h055, 3'd4, 4'h4};
        vecs[5]  = '{1'b1, 9'h055, 3'd5, 4'h5};
        vecs[6]  = '{1'b1, 9'h055, 3'd6, 4'h6};
        vecs[7]  = '{1'b1, 9'h055, 3'd7, 4'h7};
        vecs[8]  = '{1'b1, 9'h1FF, 3'd0, 4'h8};
        vecs[9]  = '{1'b1, 9'h1FF, 3'd7, 4'hF};
        vecs[10] = '{1'b1, 9'h1FF, 3'd3, 4'hB};
        vecs[11] = '{1'b0, 9'h000, 3'd0, 4'hC};
        vecs[12] = '{1'b0, 9'h000, 3'd1, 4'h3};
        vecs[13] = '{1'b0, 9'h000, 3'd7, 4'h0};
        vecs[14] = '{1'b1, 9'h055, 3'd4, 4'h4};

        // ---------------- reset ----------------
        rst_n      = 1'b0;
        addr       = '0;
        bank       = 1'b0;
        pix_sel    = '0;
        wr_valid   = 1'b0;
        wr_bank    = 1'b1;
        wr_addr    = '0;
        wr_data    = '0;
        fill_start = 1'b0;
        fill_bank  = '0;
        fill_value = '0;
        tick();
        tick();
        tick();
        check("rst_pixel", {60'd0, pixel}, 64'd0);
        check("rst_busy", {63'd0, fill_busy}, 64'd0);
        check("rst_done", {63'd0, fill_done}, 64'd0);
        check("rst_wr_ready_forced", {63'd0, wr_ready}, 64'd0);
        rst_n = 1'b1;
        #1;
        check("idle_wr_ready", {63'd0, wr_ready}, 64'd1);
        tick();
        check("idle_pixel", {60'd0, pixel}, 64'd0);
        check("idle_busy", {63'd0, fill_busy}, 64'd0);
        check("idle_done", {63'd0, fill_done}, 64'd0);

        // ---------------- host writes + pipelined read table ----------------
        bank = 1'b0;
        host_write(1'b1, 9'h055, 32'h7654_3210);
        host_write(1'b1, 9'h1FF, 32'hFEDC_BA98);
        bank = 1'b1;
        host_write(1'b0, 9'h000, 32'h0F1E_2D3C);

        // One new read per cycle; pixel for vector i appears two edges later.
        for (int i = 0; i < NVEC; i++) begin
            bank    = vecs[i].bank;
            addr    = vecs[i].addr;
            pix_sel = vecs[i].sel;
            tick();
            if (i >= 1) check($sformatf("rd_vec_%0d", i - 1), {60'd0, pixel}, {60'd0, vecs[i-1].exp});
        end
        tick();
        check($sformatf("rd_vec_%0d", NVEC - 1), {60'd0, pixel}, {60'd0, vecs[NVEC-1].exp});

        // ---------------- write then read same location ----------------
        bank = 1'b1;
        host_write(1'b0, 9'h020, 32'h0000_00A5);
        bank    = 1'b0;
        addr    = 9'h020;
        pix_sel = 3'd0;
        tick();
        pix_sel = 3'd1;
        tick();
        check("wr_then_rd_p0", {60'd0, pixel}, 64'h5);
        tick();
        check("wr_then_rd_p1", {60'd0, pixel}, 64'hA);

        // ---------------- write stall on bank conflict ----------------
        bank     = 1'b0;
        wr_bank  = 1'b0;
        wr_addr  = 9'h077;
        wr_data  = 32'h89AB_CDEF;
        wr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("stall_wr_ready_%0d", i), {63'd0, wr_ready}, 64'd0);
            tick();
        end
        bank = 1'b1;
        #1;
        check("stall_release_ready", {63'd0, wr_ready}, 64'd1);
        tick();
        wr_valid = 1'b0;
        read_pix(1'b0, 9'h077, 3'd0, p);
        check("stall_data_p0", {60'd0, p}, 64'hF);
        read_pix(1'b0, 9'h077, 3'd7, p);
        check("stall_data_p7", {60'd0, p}, 64'h8);
        read_pix(1'b0, 9'h077, 3'd3, p);
        check("stall_data_p3", {60'd0, p}, 64'hC);

        // ---------------- plain fill of bank 1 ----------------
        bank = 1'b0;
        run_fill(1'b1, 32'hAAAA_AAAA, -1, 0, busy_n, ready_hi);
        check("fill_busy_cycles", busy_n, 64'd512);
        check("fill_ready_low", {63'd0, ready_hi}, 64'd0);
        check("fill_done_pulse", {63'd0, fill_done}, 64'd1);
        tick();
        check("fill_done_single", {63'd0, fill_done}, 64'd0);
        word_bad = 0;
        for (int a = 0; a < 512; a++) begin
            read_pix(1'b1, a[ADDR_W-1:0], a[SEL_W-1:0], p);
            if (p !== 4'hA) word_bad++;
        end
        check("fill_readback_bad_words", word_bad, 64'd0);
        // Ignored mid-fill restart would have targeted bank 0.
        read_pix(1'b0, 9'h000, 3'd0, p);
        check("fill_other_bank_intact", {60'd0, p}, 64'hC);

        // ---------------- fill with 10 stall cycles ----------------
        bank = 1'b0;
        run_fill(1'b1, 32'h5555_5555, 100, 10, busy_n, ready_hi);
        check("stall_fill_busy_cycles", busy_n, 64'd522);
        check("stall_fill_ready_low", {63'd0, ready_hi}, 64'd0);
        check("stall_fill_done", {63'd0, fill_done}, 64'd1);
        tick();
        check("stall_fill_done_single", {63'd0, fill_done}, 64'd0);
        word_bad = 0;
        for (int a = 0; a < 512; a++) begin
            read_pix(1'b1, a[ADDR_W-1:0], a[SEL_W-1:0], p);
            if (p !== 4'h5) word_bad++;
        end
        check("stall_fill_readback_bad_words", word_bad, 64'd0);

        // ---------------- reset in the middle of a fill ----------------
        bank       = 1'b0;
        fill_bank  = 1'b1;
        fill_value = 32'h3333_3333;
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        check("rstfill_busy_before", {63'd0, fill_busy}, 64'd1);
        rst_n = 1'b0;
        tick();
        check("rstfill_busy_after", {63'd0, fill_busy}, 64'd0);
        check("rstfill_done_after", {63'd0, fill_done}, 64'd0);
        rst_n = 1'b1;
        tick();
        check("rstfill_done_later", {63'd0, fill_done}, 64'd0);
        check("rstfill_busy_later", {63'd0, fill_busy}, 64'd0);
        read_pix(1'b1, 9'd0, 3'd0, p);
        check("rstfill_word0", {60'd0, p}, 64'h3);
        read_pix(1'b1, 9'd99, 3'd5, p);
        check("rstfill_word99", {60'd0, p}, 64'h3);
        read_pix(1'b1, 9'd100, 3'd0, p);
        check("rstfill_word100_old", {60'd0, p}, 64'h5);
        read_pix(1'b1, 9'd511, 3'd7, p);
        check("rstfill_word511_old", {60'd0, p}, 64'h5);

        // ---------------- fill started together with a host write ----------------
        bank     = 1'b0;
        wr_bank  = 1'b1;
        wr_addr  = 9'h003;
        wr_data  = 32'h1111_1111;
        wr_valid = 1'b1;
        #1;
        check("start_with_write_ready", {63'd0, wr_ready}, 64'd1);
        run_fill(1'b1, 32'h9696_9696, -1, 0, busy_n, ready_hi);
        check("refill_busy_cycles", busy_n, 64'd512);
        check("refill_done", {63'd0, fill_done}, 64'd1);
        tick();
        check("refill_done_single", {63'd0, fill_done}, 64'd0);
        read_pix(1'b1, 9'd3, 3'd0, p);
        check("refill_overwrites_write_p0", {60'd0, p}, 64'h6);
        read_pix(1'b1, 9'd3, 3'd1, p);
        check("refill_overwrites_write_p1", {60'd0, p}, 64'h9);
        read_pix(1'b1, 9'd100, 3'd0, p);
        check("refill_word100", {60'd0, p}, 64'h6);
        read_pix(1'b1, 9'd511, 3'd7, p);
        check("refill_word511", {60'd0, p}, 64'h9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pixmem_if.md
# pixmem_if

Parametrised multi-bank pixel memory interface for the FPGA prototype top. It is the successor to the fixed two-bank, 9-bit-address, 4-bit-pixel `mem_if`. It sits between the design under test, which drives `addr`/`bank`/`pix_sel` and receives `pixel`, and a host-side loader. It adds three things:
- a word-wide write port with valid/ready handshake;
- a hardware bank-fill engine;
- a fixed, documented read latency.

## Interface

Parameters:
- `PIX_W`, 4, bits per pixel.
- `PIX_PER_WORD`, 8, pixels per memory word; power of two, ≥2. `SEL_W = $clog2(PIX_PER_WORD)`.
- `ADDR_W`, 9, word address width; depth per bank is `2**ADDR_W`.
- `NUM_BANKS`, 2, bank count; power of two, ≥2. `BANK_W = $clog2(NUM_BANKS)`.
- Derived: `WORD_W = PIX_W*PIX_PER_WORD`.

Ports:
- `clk` in 1: single clock for all logic and memory.
- `rst_n` in 1: reset, synchronous, active-low.
- `addr` in ADDR_W: display read word address.
- `bank` in BANK_W: display read bank.
- `pix_sel` in SEL_W: pixel index within the addressed word.
- `pixel` out PIX_W: selected pixel, registered.
- `wr_valid` in 1: host write request.
- `wr_ready` out 1: write accepted this cycle when high together with `wr_valid`.
- `wr_bank` in BANK_W, `wr_addr` in ADDR_W, `wr_data` in WORD_W: host write payload.
- `fill_start` in 1: single-cycle request to fill a whole bank.
- `fill_bank` in BANK_W, `fill_value` in WORD_W: fill target and data, sampled with `fill_start`.
- `fill_busy` out 1: fill engine active.
- `fill_done` out 1: one-cycle pulse on fill completion.

## Operation

Storage:
- `NUM_BANKS` independent banks, each `2**ADDR_W` × `WORD_W`.
- Each bank has one synchronous port, so it can do one read or one write per cycle.
- Memory contents are not reset.

Read path:
- Runs every cycle and is unconditional. Reads always have priority over writes.
- Stage 1: the word at `mem[bank][addr]` is read into the word register; `pix_sel` is delayed one cycle alongside it.
- Stage 2: `pixel <= word[sel_d*PIX_W +: PIX_W]`.

Host write:
- `wr_ready = (state == IDLE) && (wr_bank != bank)`. This is combinational from `bank`, `wr_bank` and state.
- On `wr_valid && wr_ready`, `mem[wr_bank][wr_addr] <= wr_data` at that edge.
- A held request with `wr_bank == bank` stalls until the display moves to another bank. No data is lost.

Fill FSM, states IDLE and FILL:
- IDLE→FILL when `fill_start` is high. On that edge: capture `fill_bank` and `fill_value`, clear the counter `cnt` to 0, and set `fill_busy` to 1.
- In FILL, if the captured bank differs from `bank`: write `fill_value` to `mem[fbank][cnt]` and increment `cnt`.
- In FILL, if the captured bank equals `bank`: stall. No write occurs and `cnt` holds.
- FILL→IDLE after the write at `cnt == 2**ADDR_W-1`. On that edge `fill_busy` clears and `fill_done` pulses for exactly one cycle.
- `wr_ready` is 0 for the whole time in FILL.
- `fill_start` while in FILL is ignored. The in-progress fill is not restarted.
- `fill_start` and an accepted host write in the same IDLE cycle: the write completes at that edge and the fill begins on the next cycle. If the addresses overlap, the fill overwrites the write.

Reset (synchronous, any state, including mid-fill):
- State → IDLE, `cnt` → 0.
- `pixel` → 0, `fill_busy` → 0, `fill_done` → 0; internal word and select registers → 0.
- `wr_ready` is forced to 0 while `rst_n` is low.
- A fill interrupted by reset leaves a partially filled bank. This is legal.

## Timing

- Read latency is 2 cycles: `addr`/`bank`/`pix_sel` presented before edge N give the corresponding `pixel` after edge N+1. Full throughput: one new address per cycle.
- Read during a write to a different bank: unaffected.
- Write-then-read of the same location: a host write at edge N is visible to a read whose address is presented before edge N+1, i.e. `pixel` updates after N+2.
- Fill duration is `2**ADDR_W` cycles plus one cycle per stall cycle. `fill_busy` is high from the edge after the `fill_start` cycle until the final write edge. `fill_done` is high in the cycle following that edge.
- `pix_sel` is pipelined with the data, so a change to `pix_sel` alone also has 2-cycle latency.

## Test plan

- Reset, then idle: `pixel` = 0, `fill_busy` = 0, `fill_done` = 0; `wr_ready` = 1 with `wr_bank`=1, `bank`=0.
- Host write `wr_bank`=1, `wr_addr`=0x055, `wr_data`=0x76543210, then set `bank`=1, `addr`=0x055 and sweep `pix_sel` 0..7 -> `pixel` = 0,1,…,7, each 2 cycles after its `pix_sel`.
- Hold `wr_valid` with `wr_bank`=`bank`=0 for 5 cycles, then set `bank`=1 -> `wr_ready` stays 0 for the 5 cycles, the write is accepted on the first cycle after the bank change, and the data reads back correctly.
- `fill_start` with `fill_bank`=1, `fill_value`=0xAAAAAAAA while `bank`=0 -> `fill_busy` is high for 512 cycles, then a single `fill_done` pulse; `wr_ready`=0 throughout; all 512 words read back as 0xA pixels.
- Same fill, but with `bank`=1 for 10 cycles mid-fill -> `fill_busy` lasts 522 cycles and every word is written exactly once.
- Assert `rst_n`=0 at `cnt`=100 during a fill -> the next cycle has `fill_busy`=0 and no `fill_done`; words 0–99 hold the fill value and word 100 keeps its old value; a new `fill_start` after reset completes normally.
